pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Sequential consumer of the load-use stall request and invalidate signal produced by hazard detection. It merges that request with a taken-branch flush and a data-memory wait handshake into one set of per-stage pipeline-register enables, flushes and bubble inserts. It tracks multi-cycle memory stalls, flags a memory timeout, and keeps a saturating stall-cycle performance counter. It sits beside the FETCH/DECODE/EXE/MEM pipeline registers and drives all of their control inputs.

## Interface
- COUNT_WIDTH, 16, width of stall_count_o.
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before error; legal range ≥ 2.

- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- stall_pipeline_i  input  stall_pipeline_sig  load-use stall request (STALL_PIPELINE / NO_STALL_PIPELINE).
- hazard_invalidate_i  input  1  invalidate companion to the stall request; asserted together with it.
- branch_taken_EXE_i  input  1  taken branch resolved in EXE.
- dmem_req_MEM_i  input  1  MEM stage is issuing a data-memory access.
- dmem_ack_i  input  1  data memory completes the access this cycle.
- enable_FETCH_o, enable_DECODE_o, enable_EXE_o, enable_MEM_o  output  1 each  pipeline-register load enables.
- flush_FETCH_o, flush_DECODE_o  output  1 each  zero the FETCH/DECODE pipeline registers.
- bubble_EXE_o  output  1  load NOP into the DECODE→EXE register.
- mem_timeout_o  output  1  sticky memory-timeout error.
- stall_count_o  output  COUNT_WIDTH  cycles with enable_FETCH_o = 0, saturating.

## Operation
- State register: RUN, MEM_WAIT or ERROR. Reset state is RUN.
- Outputs are combinational from the state and the current inputs, so they take effect in the same cycle. Counters and mem_timeout_o are registered.
- Load-use request is active when stall_pipeline_i == STALL_PIPELINE or hazard_invalidate_i == 1.
- Priority order: ERROR, then memory wait, then branch flush, then load-use stall, then normal.

**RUN state**
- Memory wait (dmem_req_MEM_i && !dmem_ack_i):
  - All enables 0; no flush; no bubble.
  - Next state MEM_WAIT; wait_cnt ← 1.
- Else, branch_taken_EXE_i:
  - All enables 1; flush_FETCH_o = flush_DECODE_o = 1.
  - Load-use request is ignored, because the instruction it concerns is being flushed.
- Else, load-use request active:
  - enable_FETCH_o = enable_DECODE_o = 0.
  - enable_EXE_o = enable_MEM_o = 1.
  - bubble_EXE_o = 1.
- Else: all enables 1; no flush or bubble.

**MEM_WAIT state**
- Without dmem_ack_i:
  - All enables 0.
  - wait_cnt increments.
  - If wait_cnt == MEM_TIMEOUT: next state ERROR, and mem_timeout_o ← 1.
- With dmem_ack_i:
  - Outputs follow the RUN rules, with the memory-wait term treated as false.
  - Next state RUN; wait_cnt ← 0.
- Branch and stall inputs are stable while frozen, because their source registers are disabled.

**ERROR state**
- All enables, flushes and bubble are 0.
- mem_timeout_o stays 1.
- Leaves only on rst_i.

**Counters**
- stall_count_o increments on every clock edge where enable_FETCH_o == 0 and rst_i == 0. This includes MEM_WAIT, load-use stalls and ERROR.
- It saturates at 2^COUNT_WIDTH−1 and does not wrap.
- wait_cnt width is $clog2(MEM_TIMEOUT+1).

## Timing
- Reset (rst_i = 1, asynchronous):
  - State is RUN; wait_cnt = 0; stall_count_o = 0; mem_timeout_o = 0.
  - All enables, flushes and bubble_EXE_o are forced to 0 while reset is asserted, regardless of inputs.
- Latency: 0 cycles from any input to the enable/flush/bubble outputs. There is 1 cycle from input to state, counter and mem_timeout_o updates.
- Load-use stall lasts exactly as long as the request. The normal case is one cycle: the bubble enters EXE, the load advances to MEM, and the request drops on the next cycle.
- A memory access acked in the same cycle as the request causes no freeze and no state change.
- A freeze of N cycles followed by an ack produces N+1 cycles in which the MEM request is observed, with the release on the ack cycle.
- Timeout: with no ack, ERROR is entered after exactly MEM_TIMEOUT cycles in MEM_WAIT.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately and clears all counters.

## Test plan
- Load-use: stall_pipeline_i = STALL_PIPELINE for 1 cycle → that cycle FETCH/DECODE enables are 0, bubble_EXE_o = 1, EXE/MEM enables are 1; next cycle all enables are 1; stall_count_o = 1.
- Branch with concurrent stall: branch_taken_EXE_i = 1 and STALL_PIPELINE together → flush_FETCH_o = flush_DECODE_o = 1, bubble_EXE_o = 0, all enables 1, stall_count_o unchanged.
- Memory wait: dmem_req_MEM_i = 1 with dmem_ack_i low for 3 cycles, then high → all enables 0 for 3 cycles, enables 1 on the ack cycle, state back to RUN, stall_count_o = 3.
- Timeout: MEM_TIMEOUT = 4, dmem_req_MEM_i held high and ack never asserted → mem_timeout_o rises after 4 MEM_WAIT cycles and stays 1; enables stay 0; stall_count_o keeps incrementing.
- Reset mid-wait: assert rst_i asynchronously during MEM_WAIT → outputs immediately 0, mem_timeout_o = 0, stall_count_o = 0; after release, idle inputs give all enables 1.
- Saturation: COUNT_WIDTH = 3 with 10 consecutive stall cycles → stall_count_o ends at 7.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: merges load-use stalls, taken-branch flushes and
// data-memory wait into per-stage enables, with a memory timeout and a stall-cycle counter.
module pipeline_stall_controller #(
  parameter int COUNT_WIDTH = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_pipeline_i,
  input  logic                   hazard_invalidate_i,
  input  logic                   branch_taken_EXE_i,
  input  logic                   dmem_req_MEM_i,
  input  logic                   dmem_ack_i,
  output logic                   enable_FETCH_o,
  output logic                   enable_DECODE_o,
  output logic                   enable_EXE_o,
  output logic                   enable_MEM_o,
  output logic                   flush_FETCH_o,
  output logic                   flush_DECODE_o,
  output logic                   bubble_EXE_o,
  output logic                   mem_timeout_o,
  output logic [COUNT_WIDTH-1:0] stall_count_o,
  output logic [1:0]             state_dbg_o
);

  localparam logic STALL_PIPELINE = 1'b1;
  localparam int   WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   load_use;
  logic                   mem_wait;

  // Memory handshake: dmem_req_MEM_i opens an access, which completes in the cycle
  // dmem_ack_i is high (possibly the same cycle); until then the whole pipe is frozen.
  assign load_use = (stall_pipeline_i == STALL_PIPELINE) || hazard_invalidate_i;
  assign mem_wait = dmem_req_MEM_i && !dmem_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      if (!enable_FETCH_o && (count_q != {COUNT_WIDTH{1'b1}}))
        count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    timeout_d       = timeout_q;
    enable_FETCH_o  = 1'b0;
    enable_DECODE_o = 1'b0;
    enable_EXE_o    = 1'b0;
    enable_MEM_o    = 1'b0;
    flush_FETCH_o   = 1'b0;
    flush_DECODE_o  = 1'b0;
    bubble_EXE_o    = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        if ((state_q == RUN && mem_wait) || (state_q == MEM_WAIT && !dmem_ack_i)) begin
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Released (or never frozen): branch flush outranks the load-use stall,
          // since the stalled instruction is the one being flushed.
          state_d         = RUN;
          wait_cnt_d      = '0;
          enable_FETCH_o  = 1'b1;
          enable_DECODE_o = 1'b1;
          enable_EXE_o    = 1'b1;
          enable_MEM_o    = 1'b1;
          if (branch_taken_EXE_i) begin
            flush_FETCH_o  = 1'b1;
            flush_DECODE_o = 1'b1;
          end else if (load_use) begin
            enable_FETCH_o  = 1'b0;
            enable_DECODE_o = 1'b0;
            bubble_EXE_o    = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (rst_i) begin
      enable_FETCH_o  = 1'b0;
      enable_DECODE_o = 1'b0;
      enable_EXE_o    = 1'b0;
      enable_MEM_o    = 1'b0;
      flush_FETCH_o   = 1'b0;
      flush_DECODE_o  = 1'b0;
      bubble_EXE_o    = 1'b0;
    end
  end

  assign mem_timeout_o = timeout_q;
  assign stall_count_o = count_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_stall_controller;

  localparam int CW = 3;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall_pipeline = 1'b0;
  logic          hazard_invalidate = 1'b0;
  logic          branch_taken = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          en_f, en_d, en_e, en_m, fl_f, fl_d, bubble, timeout;
  logic [CW-1:0] stall_count;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: frozen/error flags, cycles spent in the wait state, stall count.
  bit m_err;
  bit m_frozen;
  int m_wait_cycles;
  int m_count;

  pipeline_stall_controller #(.COUNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .stall_pipeline_i(stall_pipeline), .hazard_invalidate_i(hazard_invalidate),
    .branch_taken_EXE_i(branch_taken), .dmem_req_MEM_i(dmem_req), .dmem_ack_i(dmem_ack),
    .enable_FETCH_o(en_f), .enable_DECODE_o(en_d), .enable_EXE_o(en_e), .enable_MEM_o(en_m),
    .flush_FETCH_o(fl_f), .flush_DECODE_o(fl_d), .bubble_EXE_o(bubble),
    .mem_timeout_o(timeout), .stall_count_o(stall_count), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] dut_ctl();
    return {en_f, en_d, en_e, en_m, fl_f, fl_d, bubble};
  endfunction

  // Drive one cycle of inputs, check outputs against the model, clock, update model.
  task automatic step(input bit sp, input bit inv, input bit br, input bit req, input bit ack,
                      input string tag);
    logic [6:0] exp;
    bit frozen_now;
    stall_pipeline = sp; hazard_invalidate = inv; branch_taken = br;
    dmem_req = req; dmem_ack = ack;
    #2;
    frozen_now = m_frozen ? !ack : (req && !ack);
    if (m_err || frozen_now)  exp = 7'b0000_000;
    else if (br)              exp = 7'b1111_110;
    else if (sp || inv)       exp = 7'b0011_001;
    else                      exp = 7'b1111_000;
    check({tag, ".ctl"}, 16'(dut_ctl()), 16'(exp));
    check({tag, ".cnt"}, 16'(stall_count), 16'(m_count));
    check({tag, ".tmo"}, 16'(timeout), 16'(m_err));
    @(posedge clk);
    if (!exp[6] && m_count < CMAX) m_count++;
    if (!m_err) begin
      if (frozen_now) begin
        if (m_frozen) begin
          m_wait_cycles++;
          if (m_wait_cycles == TO) m_err = 1;
        end
        m_frozen = 1;
      end else begin
        m_frozen = 0;
        m_wait_cycles = 0;
      end
    end
    #1;
  endtask

  // Asynchronous reset mid-cycle while inputs would otherwise request activity.
  task automatic do_reset(input string tag);
    stall_pipeline = 1'b0; hazard_invalidate = 1'b0; branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check({tag, ".rst_ctl"}, 16'(dut_ctl()), 16'd0);
    check({tag, ".rst_cnt"}, 16'(stall_count), 16'd0);
    check({tag, ".rst_tmo"}, 16'(timeout), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_err = 0; m_frozen = 0; m_wait_cycles = 0; m_count = 0;
  endtask

  initial begin
    do_reset("init");

    // Load-use: one stall cycle then normal.
    step(1, 0, 0, 0, 0, "lu0");
    step(0, 0, 0, 0, 0, "lu1");
    step(0, 1, 0, 0, 0, "inv");
    // Branch with concurrent stall: flush wins, count unchanged.
    step(1, 1, 1, 0, 0, "br_st");
    step(0, 0, 0, 0, 0, "br_after");
    do_reset("r1");

    // Memory wait: three frozen cycles then ack.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, $sformatf("mw%0d", i));
    step(0, 0, 0, 1, 1, "mw_ack");
    step(0, 0, 0, 0, 0, "mw_after");
    // Same-cycle ack: no freeze.
    step(0, 0, 0, 1, 1, "mw_fast");
    step(1, 0, 0, 0, 0, "mw_fast_lu");
    do_reset("r2");

    // Timeout: request never acked.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, $sformatf("to%0d", i));
    step(0, 0, 0, 1, 1, "to_ack_ignored");
    do_reset("r3");

    // Reset in the middle of a wait, then idle.
    step(0, 0, 0, 1, 0, "rm0");
    step(0, 0, 0, 1, 0, "rm1");
    do_reset("rm");
    step(0, 0, 0, 0, 0, "rm_idle");

    // Saturation: ten stall cycles.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, $sformatf("sat%0d", i));
    step(0, 0, 0, 0, 0, "sat_end");
    do_reset("r4");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset("rnd_rst");
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
